// File: rtl/rx_medida_7o1.sv
`default_nettype none
// ============================================================================
// Module   : rx_medida_7o1
// Desc     : 7O1 UART receiver assembling "units,tens,hundreds,#" into a
//            3-digit BCD measurement. Optional idle timeout: RX_TIMEOUT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module rx_medida_7o1 #(
    parameter int CLKS_PER_BIT = 434,
    parameter int TIMEOUT_CLKS = 50_000_000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        entrada_serial,
    output logic [11:0] medida,
    output logic        pronto,
    output logic        erro,
    output logic [2:0]  db_estado_rx,
    output logic [1:0]  db_estado_msg
);

    localparam int                 c_cnt_w = $clog2(CLKS_PER_BIT);
    localparam logic [c_cnt_w-1:0] c_half  = c_cnt_w'(CLKS_PER_BIT / 2 - 1);
    localparam logic [c_cnt_w-1:0] c_last  = c_cnt_w'(CLKS_PER_BIT - 1);

    localparam logic [2:0] c_rx_idle  = 3'd0;
    localparam logic [2:0] c_rx_start = 3'd1;
    localparam logic [2:0] c_rx_data  = 3'd2;
    localparam logic [2:0] c_rx_par   = 3'd3;
    localparam logic [2:0] c_rx_stop  = 3'd4;

    localparam logic [1:0] c_msg_d0   = 2'd0;
    localparam logic [1:0] c_msg_d1   = 2'd1;
    localparam logic [1:0] c_msg_d2   = 2'd2;
    localparam logic [1:0] c_msg_hash = 2'd3;

    if (CLKS_PER_BIT < 8 || TIMEOUT_CLKS < 1) begin : g_param_check
        $error("rx_medida_7o1: CLKS_PER_BIT must be >= 8 and TIMEOUT_CLKS >= 1");
    end

    logic               r_rx_meta;
    logic               r_rx_s;
    logic [2:0]         r_st_rx;
    logic [c_cnt_w-1:0] r_clk_cnt;
    logic [2:0]         r_bit_cnt;
    logic [6:0]         r_dado;
    logic               r_par;
    logic               r_char_ok;
    logic               r_char_err;
    logic               r_cls_digit;
    logic               r_cls_hash;
    logic               r_cls_err;
    logic [3:0]         r_nibble;
    logic [1:0]         r_st_msg;
    logic [3:0]         r_u;
    logic [3:0]         r_t;
    logic [3:0]         r_h;
    logic [11:0]        r_medida;
    logic               r_pronto;
    logic               r_erro;

    logic               w_bit_end;
    logic [1:0]         w_st_msg_nx;
    logic [3:0]         w_u_nx;
    logic [3:0]         w_t_nx;
    logic [3:0]         w_h_nx;
    logic [11:0]        w_medida_nx;
    logic               w_pronto_nx;
    logic               w_erro_nx;

    always_ff @(posedge clock) begin
        if (!reset) begin
            r_rx_meta <= 1'b1;
            r_rx_s    <= 1'b1;
        end else begin
            r_rx_meta <= entrada_serial;
            r_rx_s    <= r_rx_meta;
        end
    end

    assign w_bit_end = (r_clk_cnt == c_last);

    // Frame FSM: after the half-bit start check, every sample is one full bit apart
    always_ff @(posedge clock) begin
        if (!reset) begin
            r_st_rx    <= c_rx_idle;
            r_clk_cnt  <= '0;
            r_bit_cnt  <= '0;
            r_dado     <= '0;
            r_par      <= 1'b0;
            r_char_ok  <= 1'b0;
            r_char_err <= 1'b0;
        end else begin
            r_char_ok  <= 1'b0;
            r_char_err <= 1'b0;
            case (r_st_rx)
                c_rx_idle: begin
                    r_clk_cnt <= '0;
                    r_bit_cnt <= '0;
                    if (!r_rx_s) r_st_rx <= c_rx_start;
                end
                c_rx_start: begin
                    if (r_clk_cnt == c_half) begin
                        r_clk_cnt <= '0;
                        r_st_rx   <= r_rx_s ? c_rx_idle : c_rx_data;
                    end else begin
                        r_clk_cnt <= r_clk_cnt + 1'b1;
                    end
                end
                c_rx_data: begin
                    r_clk_cnt <= w_bit_end ? '0 : r_clk_cnt + 1'b1;
                    if (w_bit_end) begin
                        r_dado <= {r_rx_s, r_dado[6:1]};
                        if (r_bit_cnt == 3'd6) r_st_rx   <= c_rx_par;
                        else                   r_bit_cnt <= r_bit_cnt + 1'b1;
                    end
                end
                c_rx_par: begin
                    r_clk_cnt <= w_bit_end ? '0 : r_clk_cnt + 1'b1;
                    if (w_bit_end) begin
                        r_par   <= r_rx_s;
                        r_st_rx <= c_rx_stop;
                    end
                end
                c_rx_stop: begin
                    r_clk_cnt <= w_bit_end ? '0 : r_clk_cnt + 1'b1;
                    if (w_bit_end) begin
                        r_st_rx <= c_rx_idle;
                        if (r_rx_s && (^{r_dado, r_par})) r_char_ok  <= 1'b1;
                        else                               r_char_err <= 1'b1;
                    end
                end
                default: r_st_rx <= c_rx_idle;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            r_cls_digit <= 1'b0;
            r_cls_hash  <= 1'b0;
            r_cls_err   <= 1'b0;
            r_nibble    <= '0;
        end else begin
            r_cls_digit <= r_char_ok && (r_dado[6:4] == 3'b011) && (r_dado[3:0] <= 4'd9);
            r_cls_hash  <= r_char_ok && (r_dado == 7'h23);
            r_cls_err   <= r_char_err ||
                           (r_char_ok && (r_dado != 7'h23) &&
                            !((r_dado[6:4] == 3'b011) && (r_dado[3:0] <= 4'd9)));
            r_nibble    <= r_dado[3:0];
        end
    end

`ifdef RX_TIMEOUT_EN
    localparam int c_to_w = $clog2(TIMEOUT_CLKS + 1);

    logic [c_to_w-1:0] r_to_cnt;
    logic              w_timeout;

    assign w_timeout = (r_to_cnt == c_to_w'(TIMEOUT_CLKS));

    always_ff @(posedge clock) begin
        if (!reset || r_char_ok || r_char_err || (r_st_msg == c_msg_d0) || w_timeout) begin
            r_to_cnt <= '0;
        end else if (r_st_rx == c_rx_idle) begin
            r_to_cnt <= r_to_cnt + 1'b1;
        end
    end
`endif

    // Any rejected character or misplaced '#' resynchronises to D0
    always_comb begin
        w_st_msg_nx = r_st_msg;
        w_u_nx      = r_u;
        w_t_nx      = r_t;
        w_h_nx      = r_h;
        w_medida_nx = r_medida;
        w_pronto_nx = 1'b0;
        w_erro_nx   = 1'b0;
        if (r_cls_err) begin
            w_st_msg_nx = c_msg_d0;
            w_erro_nx   = 1'b1;
        end else if (r_cls_hash) begin
            w_st_msg_nx = c_msg_d0;
            if (r_st_msg == c_msg_hash) begin
                w_medida_nx = {r_h, r_t, r_u};
                w_pronto_nx = 1'b1;
            end else begin
                w_erro_nx   = 1'b1;
            end
        end else if (r_cls_digit) begin
            case (r_st_msg)
                c_msg_d0: begin
                    w_u_nx      = r_nibble;
                    w_st_msg_nx = c_msg_d1;
                end
                c_msg_d1: begin
                    w_t_nx      = r_nibble;
                    w_st_msg_nx = c_msg_d2;
                end
                c_msg_d2: begin
                    w_h_nx      = r_nibble;
                    w_st_msg_nx = c_msg_hash;
                end
                default: begin
                    w_st_msg_nx = c_msg_d0;
                    w_erro_nx   = 1'b1;
                end
            endcase
        end
`ifdef RX_TIMEOUT_EN
        else if (w_timeout) begin
            w_st_msg_nx = c_msg_d0;
            w_erro_nx   = 1'b1;
        end
`endif
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            r_st_msg <= c_msg_d0;
            r_u      <= '0;
            r_t      <= '0;
            r_h      <= '0;
            r_medida <= '0;
            r_pronto <= 1'b0;
            r_erro   <= 1'b0;
        end else begin
            r_st_msg <= w_st_msg_nx;
            r_u      <= w_u_nx;
            r_t      <= w_t_nx;
            r_h      <= w_h_nx;
            r_medida <= w_medida_nx;
            r_pronto <= w_pronto_nx;
            r_erro   <= w_erro_nx;
        end
    end

    assign medida        = r_medida;
    assign pronto        = r_pronto;
    assign erro          = r_erro;
    assign db_estado_rx  = r_st_rx;
    assign db_estado_msg = r_st_msg;

endmodule
`default_nettype wire

// File: tb/tb_rx_medida_7o1.sv
`default_nettype none
// ============================================================================
// Module   : tb_rx_medida_7o1
// Desc     : Scoreboard bench for rx_medida_7o1: directed messages plus random
//            7O1 traffic against a message-level reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_rx_medida_7o1;

    localparam int c_cpb = 16;
    localparam int c_to  = 2000;
    localparam int c_per = 10;

    logic        clock = 1'b0;
    logic        reset;
    logic        entrada_serial;
    logic [11:0] medida;
    logic        pronto;
    logic        erro;
    logic [2:0]  db_estado_rx;
    logic [1:0]  db_estado_msg;

    rx_medida_7o1 #(
        .CLKS_PER_BIT (c_cpb),
        .TIMEOUT_CLKS (c_to)
    ) u_dut (
        .clock          (clock),
        .reset          (reset),
        .entrada_serial (entrada_serial),
        .medida         (medida),
        .pronto         (pronto),
        .erro           (erro),
        .db_estado_rx   (db_estado_rx),
        .db_estado_msg  (db_estado_msg)
    );

    always #(c_per / 2) clock = ~clock;

    typedef struct {
        bit          is_ok;
        logic [11:0] val;
        time         tmin;
        time         tmax;
    } exp_t;

    exp_t        sb_q[$];
    exp_t        mon_e;
    int          n_cmp = 0;
    int          n_bad = 0;
    bit          mon_en = 1'b0;
    logic [11:0] last_medida = '0;

    int          m_cnt = 0;
    logic [3:0]  m_dig[3] = '{4'd0, 4'd0, 4'd0};
    logic [11:0] m_medida = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic odd_par(input logic [6:0] d);
        return ~(^d);
    endfunction

    task automatic push_exp(input bit ok, input logic [11:0] val, input time tmin, input time tmax);
        exp_t e;
        e.is_ok = ok;
        e.val   = val;
        e.tmin  = tmin;
        e.tmax  = tmax;
        sb_q.push_back(e);
    endtask

    // Message-level model: count accepted digits, '#' closes only after three
    task automatic model_char(input logic [6:0] d, input logic par, input logic stp, input time t0);
        time tmin;
        time tmax;
        bit  frame_ok;
        bit  is_dig;
        tmin     = t0 + time'((19 * c_cpb / 2) * c_per);
        tmax     = t0 + time'((10 * c_cpb + 4) * c_per);
        frame_ok = ((^d) ^ par) && stp;
        is_dig   = (d >= 7'h30) && (d <= 7'h39);
        if (frame_ok && is_dig && m_cnt < 3) begin
            m_dig[m_cnt] = d[3:0];
            m_cnt++;
        end else begin
            if (frame_ok && d == 7'h23 && m_cnt == 3) begin
                m_medida = {m_dig[2], m_dig[1], m_dig[0]};
                push_exp(1'b1, m_medida, tmin, tmax);
            end else begin
                push_exp(1'b0, m_medida, tmin, tmax);
            end
            m_cnt = 0;
        end
    endtask

    task automatic send_char(input logic [6:0] d, input logic par, input logic stp, output time t0);
        @(negedge clock);
        t0 = $time;
        model_char(d, par, stp, t0);
        entrada_serial = 1'b0;
        repeat (c_cpb) @(negedge clock);
        for (int i = 0; i < 7; i++) begin
            entrada_serial = d[i];
            repeat (c_cpb) @(negedge clock);
        end
        entrada_serial = par;
        repeat (c_cpb) @(negedge clock);
        entrada_serial = stp;
        repeat (c_cpb - 1) @(negedge clock);
        entrada_serial = 1'b1;
    endtask

    task automatic send_msg(input string s);
        time t;
        for (int i = 0; i < s.len(); i++) begin
            logic [7:0] ch;
            ch = s[i];
            send_char(ch[6:0], odd_par(ch[6:0]), 1'b1, t);
        end
        repeat (8) @(negedge clock);
    endtask

    always @(negedge clock) begin
        if (mon_en) begin
            if (pronto || erro) begin
                chk("pronto_erro_exclusive", 32'(pronto & erro), 32'd0);
                if (sb_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_event: pronto=%0b erro=%0b medida=0x%0h, none expected at %0t",
                             pronto, erro, medida, $time);
                end else begin
                    mon_e = sb_q.pop_front();
                    chk("event_kind_pronto", 32'(pronto), 32'(mon_e.is_ok));
                    chk("event_medida", 32'(medida), 32'(mon_e.val));
                    chk("event_in_time_window", 32'(($time >= mon_e.tmin) && ($time <= mon_e.tmax)), 32'd1);
                end
            end else if (medida !== last_medida) begin
                chk("medida_hold", 32'(medida), 32'(last_medida));
            end
        end
        last_medida = medida;
    end

    initial begin
        time t;

        reset          = 1'b0;
        entrada_serial = 1'b1;
        repeat (4) @(negedge clock);
        chk("reset_medida", 32'(medida), 32'd0);
        chk("reset_pronto", 32'(pronto), 32'd0);
        chk("reset_erro", 32'(erro), 32'd0);
        chk("reset_estado_rx", 32'(db_estado_rx), 32'd0);
        chk("reset_estado_msg", 32'(db_estado_msg), 32'd0);
        reset = 1'b1;
        repeat (3) @(negedge clock);
        mon_en = 1'b1;

        send_msg("321#");
        chk("msg_123", 32'(medida), 32'h123);

        send_char(7'h33, odd_par(7'h33), 1'b1, t);
        send_char(7'h32, ~odd_par(7'h32), 1'b1, t);
        send_msg("1#");
        chk("bad_parity_keeps_123", 32'(medida), 32'h123);

        @(negedge clock);
        entrada_serial = 1'b0;
        repeat (4) @(negedge clock);
        entrada_serial = 1'b1;
        repeat (2 * c_cpb) @(negedge clock);
        send_msg("900#");
        chk("glitch_then_009", 32'(medida), 32'h009);

        send_msg("A567#");
        chk("invalid_then_765", 32'(medida), 32'h765);

        // Abort the second '4' with a reset pulse during data bit 2 (line high)
        send_char(7'h34, odd_par(7'h34), 1'b1, t);
        @(negedge clock);
        entrada_serial = 1'b0;
        repeat (c_cpb) @(negedge clock);
        for (int i = 0; i < 2; i++) begin
            entrada_serial = 1'b0;
            repeat (c_cpb) @(negedge clock);
        end
        entrada_serial = 1'b1;
        repeat (c_cpb / 2) @(negedge clock);
        mon_en = 1'b0;
        reset  = 1'b0;
        @(negedge clock);
        reset = 1'b1;
        chk("midreset_medida", 32'(medida), 32'd0);
        chk("midreset_pronto", 32'(pronto), 32'd0);
        chk("midreset_erro", 32'(erro), 32'd0);
        chk("midreset_estado_rx", 32'(db_estado_rx), 32'd0);
        chk("midreset_estado_msg", 32'(db_estado_msg), 32'd0);
        m_cnt    = 0;
        m_medida = '0;
        sb_q.delete();
        repeat (2) @(negedge clock);
        mon_en = 1'b1;
        repeat (3 * c_cpb) @(negedge clock);
        send_msg("444#");
        chk("after_reset_444", 32'(medida), 32'h444);

`ifdef RX_TIMEOUT_EN
        send_char(7'h31, odd_par(7'h31), 1'b1, t);
        send_char(7'h32, odd_par(7'h32), 1'b1, t);
        push_exp(1'b0, m_medida, t + time'(c_to * c_per), t + time'((c_to + 12 * c_cpb) * c_per));
        m_cnt = 0;
        repeat (c_to + 20 * c_cpb) @(negedge clock);
        chk("timeout_estado_msg", 32'(db_estado_msg), 32'd0);
        send_msg("888#");
        chk("after_timeout_888", 32'(medida), 32'h888);
`endif

        for (int m = 0; m < 40; m++) begin
            for (int k = 0; k < 4; k++) begin
                logic [6:0] d;
                logic       par;
                logic       stp;
                int         r;
                d = (k == 3) ? 7'h23 : 7'(32'h30 + $urandom_range(0, 9));
                r = int'($urandom_range(0, 29));
                if (r == 0)      d = 7'h23;
                else if (r == 1) d = 7'(32'h30 + $urandom_range(0, 9));
                else if (r == 2) d = 7'($urandom_range('h3a, 'h7f));
                par = odd_par(d);
                stp = 1'b1;
                if (r == 3) par = ~par;
                if (r == 4) stp = 1'b0;
                send_char(d, par, stp, t);
                if (!stp)
                    repeat (3 * c_cpb) @(negedge clock);
                else if ($urandom_range(0, 3) == 0)
                    repeat ($urandom_range(1, 2 * c_cpb)) @(negedge clock);
            end
        end

        repeat (3 * c_cpb) @(negedge clock);
        chk("scoreboard_drained", 32'(sb_q.size()), 32'd0);
        chk("final_medida", 32'(medida), 32'(m_medida));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
